// File: rtl/branch_predict_ras.sv
// Fetch-stage branch predictor: tagged BTB with entry types, local/gshare
// direction predictor and a commit-driven return address stack.
module branch_predict_ras #(
  parameter int BTB_IDX_BITS = 8,
  parameter int TAG_BITS     = 6,
  parameter int LHT_IDX_BITS = 5,
  parameter int HIST_BITS    = 3,
  parameter int CTR_BITS     = 2,
  parameter int MODE         = 0,
  parameter int RAS_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [31:1]                  chk_pc,
  output logic                         predict,
  output logic [31:0]                  predict_pc,
  input  logic                         upd_we,
  input  logic [31:2]                  upd_pc,
  input  logic [1:0]                   upd_type,
  input  logic                         upd_taken,
  input  logic [31:0]                  upd_target,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int BTB_N = 1 << BTB_IDX_BITS;
  localparam int LHT_N = 1 << LHT_IDX_BITS;
  localparam int PW    = LHT_IDX_BITS + HIST_BITS;
  localparam int PHT_N = 1 << PW;
  localparam int RP    = $clog2(RAS_DEPTH);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
  localparam logic [RP:0]         RAS_FULL = (RP + 1)'(RAS_DEPTH);

  typedef enum logic [1:0] {
    T_COND = 2'd0,
    T_JUMP = 2'd1,
    T_CALL = 2'd2,
    T_RET  = 2'd3
  } br_type_e;

  logic [BTB_N-1:0]     btb_valid;
  logic [TAG_BITS-1:0]  btb_tag    [BTB_N];
  logic [31:0]          btb_target [BTB_N];
  br_type_e             btb_type   [BTB_N];
  logic [CTR_BITS-1:0]  pht        [PHT_N];
  logic [HIST_BITS-1:0] lht        [LHT_N];
  logic [HIST_BITS-1:0] ghr;
  logic [31:0]          ras        [RAS_DEPTH];
  logic [RP-1:0]        ras_ptr;

  // Local mode concatenates PC bits with that PC's history; gshare folds the
  // global history into the low PC bits.
  function automatic logic [PW-1:0] calc_pidx(input logic [31:2] pc,
                                               input logic [HIST_BITS-1:0] hist);
    if (MODE == 1)
      return pc[PW+1:2] ^ {{LHT_IDX_BITS{1'b0}}, hist};
    else
      return {pc[LHT_IDX_BITS+1:2], hist};
  endfunction

  logic [BTB_IDX_BITS-1:0] chk_idx;
  logic [TAG_BITS-1:0]     chk_tag;
  logic [LHT_IDX_BITS-1:0] chk_lidx;
  logic [PW-1:0]           chk_pidx;
  logic                    chk_hit;
  logic [31:0]             ras_top;

  assign chk_idx  = chk_pc[BTB_IDX_BITS+1:2];
  assign chk_tag  = chk_pc[BTB_IDX_BITS+TAG_BITS+1:BTB_IDX_BITS+2];
  assign chk_lidx = chk_pc[LHT_IDX_BITS+1:2];
  assign chk_pidx = calc_pidx(chk_pc[31:2], (MODE == 1) ? ghr : lht[chk_lidx]);
  assign chk_hit  = btb_valid[chk_idx] && (btb_tag[chk_idx] == chk_tag);
  assign ras_top  = ras[ras_ptr - RP'(1)];

  assign predict = rstn & ~chk_pc[1] & chk_hit &
                   ((btb_type[chk_idx] != T_COND) | pht[chk_pidx][CTR_BITS-1]);

  always_comb begin
    predict_pc = '0;
    if (chk_hit) begin
      if (btb_type[chk_idx] == T_RET && ras_count != '0)
        predict_pc = ras_top;
      else
        predict_pc = btb_target[chk_idx];
    end
  end

  logic [BTB_IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]     upd_tag;
  logic [LHT_IDX_BITS-1:0] upd_lidx;
  logic [HIST_BITS-1:0]    upd_hist;
  logic [HIST_BITS-1:0]    hist_next;
  logic [PW-1:0]           upd_pidx;
  logic                    upd_eff_taken;
  logic                    upd_cond;

  assign upd_idx       = upd_pc[BTB_IDX_BITS+1:2];
  assign upd_tag       = upd_pc[BTB_IDX_BITS+TAG_BITS+1:BTB_IDX_BITS+2];
  assign upd_lidx      = upd_pc[LHT_IDX_BITS+1:2];
  assign upd_hist      = (MODE == 1) ? ghr : lht[upd_lidx];
  assign hist_next     = HIST_BITS'({upd_hist, upd_taken});
  assign upd_pidx      = calc_pidx(upd_pc, upd_hist);
  assign upd_cond      = (upd_type == T_COND);
  assign upd_eff_taken = ~upd_cond | upd_taken;

  // Only the valid bits need reset; payload is ignored until valid is set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      btb_valid <= '0;
    else if (upd_we && upd_eff_taken)
      btb_valid[upd_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (upd_we && upd_eff_taken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= upd_target;
      btb_type[upd_idx]   <= br_type_e'(upd_type);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PHT_N; i++)
        pht[i] <= CTR_INIT;
    end else if (upd_we && upd_cond) begin
      if (upd_taken && pht[upd_pidx] != CTR_MAX)
        pht[upd_pidx] <= pht[upd_pidx] + CTR_BITS'(1);
      else if (!upd_taken && pht[upd_pidx] != '0)
        pht[upd_pidx] <= pht[upd_pidx] - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ghr <= '0;
      for (int i = 0; i < LHT_N; i++)
        lht[i] <= '0;
    end else if (upd_we && upd_cond) begin
      if (MODE == 1)
        ghr <= hist_next;
      else
        lht[upd_lidx] <= hist_next;
    end
  end

  // A push into a full stack reuses the oldest slot, since the write pointer
  // wraps onto it; the count just saturates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ras_ptr   <= '0;
      ras_count <= '0;
    end else if (upd_we) begin
      if (upd_type == T_CALL) begin
        ras_ptr <= ras_ptr + RP'(1);
        if (ras_count != RAS_FULL)
          ras_count <= ras_count + (RP + 1)'(1);
      end else if (upd_type == T_RET && ras_count != '0) begin
        ras_ptr   <= ras_ptr - RP'(1);
        ras_count <= ras_count - (RP + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd_we && upd_type == T_CALL)
      ras[ras_ptr] <= {upd_pc, 2'b00} + 32'd4;
  end

endmodule

// File: tb/tb_branch_predict_ras.sv
// Bench for branch_predict_ras: local and gshare instances share one stimulus
// stream and are compared against a queue/array reference model.
module tb_branch_predict_ras;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] look_pc = '0;
  logic        upd_we = 1'b0;
  logic [31:0] upd_pc32 = '0;
  logic [1:0]  upd_type = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;

  logic        predict0, predict1;
  logic [31:0] predict_pc0, predict_pc1;
  logic [3:0]  ras_count0, ras_count1;

  always #5 clk = ~clk;

  branch_predict_ras #(.MODE(0)) dut0 (
    .clk(clk), .rstn(rstn), .chk_pc(look_pc[31:1]),
    .predict(predict0), .predict_pc(predict_pc0),
    .upd_we(upd_we), .upd_pc(upd_pc32[31:2]), .upd_type(upd_type),
    .upd_taken(upd_taken), .upd_target(upd_target), .ras_count(ras_count0));

  branch_predict_ras #(.MODE(1)) dut1 (
    .clk(clk), .rstn(rstn), .chk_pc(look_pc[31:1]),
    .predict(predict1), .predict_pc(predict_pc1),
    .upd_we(upd_we), .upd_pc(upd_pc32[31:2]), .upd_type(upd_type),
    .upd_taken(upd_taken), .upd_target(upd_target), .ras_count(ras_count1));

  bit          m_valid  [256];
  int          m_tag    [256];
  logic [31:0] m_target [256];
  int          m_type   [256];
  int          m_pht    [2][256];
  int          m_lht    [32];
  int          m_ghr;
  logic [31:0] m_ras    [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i]  = 1'b0;
      m_pht[0][i] = 1;
      m_pht[1][i] = 1;
    end
    for (int i = 0; i < 32; i++) m_lht[i] = 0;
    m_ghr = 0;
    m_ras.delete();
  endfunction

  function automatic int m_pidx(input int m, input logic [31:0] pc);
    int word = int'(pc >> 2);
    int li   = word % 32;
    if (m == 0) return li * 8 + m_lht[li];
    return (word % 256) ^ m_ghr;
  endfunction

  function automatic void m_lookup(input int m, input logic [31:0] pc,
                                   output logic [31:0] pred, output logic [31:0] ppc);
    int  idx = int'((pc >> 2) % 256);
    int  tag = int'((pc >> 10) % 64);
    bit  hit = m_valid[idx] && (m_tag[idx] == tag);
    pred = 0;
    ppc  = 0;
    if (hit) begin
      if (pc[1] == 1'b0 && (m_type[idx] != 0 || m_pht[m][m_pidx(m, pc)] >= 2)) pred = 1;
      if (m_type[idx] == 3 && m_ras.size() > 0) ppc = m_ras[$];
      else ppc = m_target[idx];
    end
  endfunction

  function automatic void m_update(input logic [31:0] pc, input int typ, input bit taken,
                                   input logic [31:0] tgt);
    int idx = int'((pc >> 2) % 256);
    int li  = int'((pc >> 2) % 32);
    int p;
    if (typ != 0 || taken) begin
      m_valid[idx]  = 1'b1;
      m_tag[idx]    = int'((pc >> 10) % 64);
      m_target[idx] = tgt;
      m_type[idx]   = typ;
    end
    if (typ == 0) begin
      for (int m = 0; m < 2; m++) begin
        p = m_pidx(m, pc);
        if (taken && m_pht[m][p] < 3) m_pht[m][p]++;
        else if (!taken && m_pht[m][p] > 0) m_pht[m][p]--;
      end
      m_lht[li] = (m_lht[li] * 2 + int'(taken)) % 8;
      m_ghr     = (m_ghr * 2 + int'(taken)) % 8;
    end else if (typ == 2) begin
      m_ras.push_back(pc + 32'd4);
      if (m_ras.size() > 8) void'(m_ras.pop_front());
    end else if (typ == 3) begin
      if (m_ras.size() > 0) void'(m_ras.pop_back());
    end
  endfunction

  task automatic compare_model();
    logic [31:0] ep, epc;
    m_lookup(0, look_pc, ep, epc);
    check("local_predict", 32'(predict0), ep);
    check("local_predict_pc", predict_pc0, epc);
    check("local_ras_count", 32'(ras_count0), 32'(m_ras.size()));
    m_lookup(1, look_pc, ep, epc);
    check("gshare_predict", 32'(predict1), ep);
    check("gshare_predict_pc", predict_pc1, epc);
    check("gshare_ras_count", 32'(ras_count1), 32'(m_ras.size()));
  endtask

  // One cycle: lookup checked against the pre-edge model, then the update lands.
  task automatic step(input logic [31:0] lpc, input bit we, input logic [31:0] upc,
                      input int typ, input bit tk, input logic [31:0] tgt);
    @(negedge clk);
    look_pc    = lpc;
    upd_we     = we;
    upd_pc32   = upc & 32'hFFFF_FFFC;
    upd_type   = 2'(typ);
    upd_taken  = tk;
    upd_target = tgt;
    #1;
    compare_model();
    @(posedge clk);
    if (we) m_update(upd_pc32, typ, tk, tgt);
  endtask

  task automatic look(input logic [31:0] pc);
    @(negedge clk);
    look_pc = pc;
    upd_we  = 1'b0;
    #1;
  endtask

  // Reset arrives with a call pending so the discarded update is exercised.
  task automatic do_reset();
    @(negedge clk);
    upd_we   = 1'b1;
    upd_type = 2'd2;
    upd_pc32 = 32'h0000_0600;
    rstn     = 1'b0;
    #1;
    check("rst_predict", {predict1, predict0}, 32'd0);
    check("rst_predict_pc", predict_pc0 | predict_pc1, 32'd0);
    check("rst_ras_count", {ras_count1, ras_count0}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn   = 1'b1;
    upd_we = 1'b0;
  endtask

  logic [31:0] pool [16];

  initial begin
    int typ;
    bit tk;
    logic [31:0] lpc;

    model_reset();
    do_reset();

    look(32'h100);
    check("reset_lookup_predict", {predict1, predict0}, 32'd0);
    check("reset_lookup_pc", predict_pc0 | predict_pc1, 32'd0);
    check("reset_lookup_ras", {ras_count1, ras_count0}, 32'd0);

    for (int i = 0; i < 5; i++) step(32'h100, 1'b1, 32'h100, 0, 1'b1, 32'h80);
    look(32'h100);
    check("train_taken_local", 32'(predict0), 32'd1);
    check("train_taken_gshare", 32'(predict1), 32'd1);
    check("train_target", predict_pc0, 32'h80);
    for (int i = 0; i < 5; i++) step(32'h100, 1'b1, 32'h100, 0, 1'b0, 32'h80);
    look(32'h100);
    check("train_nt_local", 32'(predict0), 32'd0);
    check("train_nt_gshare", 32'(predict1), 32'd0);
    check("train_nt_target_kept", predict_pc1, 32'h80);

    step(32'h100, 1'b1, 32'h100, 1, 1'b0, 32'h200);
    look(32'h500);
    check("tag_alias_predict", {predict1, predict0}, 32'd0);
    look(32'h100);
    check("jump_predict", {predict1, predict0}, 32'd3);
    check("jump_target", predict_pc0, 32'h200);

    do_reset();
    step(32'h40, 1'b1, 32'h40, 2, 1'b0, 32'h1000);
    step(32'h300, 1'b1, 32'h300, 3, 1'b0, 32'h44);
    step(32'h50, 1'b1, 32'h50, 2, 1'b0, 32'h2000);
    look(32'h300);
    check("ras_ret_predict", 32'(predict0), 32'd1);
    check("ras_top_after_call", predict_pc0, 32'h54);
    step(32'h300, 1'b1, 32'h300, 3, 1'b0, 32'h44);
    look(32'h300);
    check("ras_after_pop", predict_pc1, 32'h44);
    check("ras_empty_count", 32'(ras_count0), 32'd0);

    do_reset();
    step(32'h300, 1'b1, 32'h300, 3, 1'b0, 32'h1234);
    for (int i = 0; i < 9; i++) step(32'h300, 1'b1, 32'(i * 4), 2, 1'b0, 32'h900);
    look(32'h300);
    check("ras_full_count", 32'(ras_count0), 32'd8);
    check("ras_full_top", predict_pc0, 32'h24);
    for (int i = 0; i < 9; i++) step(32'h300, 1'b1, 32'h300, 3, 1'b0, 32'h1234);
    look(32'h300);
    check("ras_drained_count", 32'(ras_count1), 32'd0);
    check("ras_drained_btb", predict_pc1, 32'h1234);

    do_reset();
    for (int i = 0; i < 12; i++) step(32'h100, 1'b1, 32'h100, 0, (i % 2) == 0, 32'h80);
    for (int i = 0; i < 4; i++) begin
      look(32'h100);
      check("alt_gshare", 32'(predict1), 32'((i % 2) == 0));
      check("alt_local", 32'(predict0), 32'((i % 2) == 0));
      step(32'h100, 1'b1, 32'h100, 0, (i % 2) == 0, 32'h80);
    end

    for (int i = 0; i < 16; i++)
      pool[i] = ($urandom() & 32'hFFFF_0000) | (32'($urandom_range(0, 3)) << 10) |
                (32'($urandom_range(0, 7)) << 2);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 750 == 749) do_reset();
      lpc = pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) lpc = lpc | 32'h2;
      typ = ($urandom_range(0, 9) < 5) ? 0 : int'($urandom_range(1, 3));
      tk  = $urandom_range(0, 1) == 1;
      step(lpc, $urandom_range(0, 9) < 7, pool[$urandom_range(0, 15)], typ, tk, $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
